// File: rtl/comefa_rf_bank.sv
// comefa_rf_bank: parametrised flop register bank with masked direct
// writes, a write-first registered read port and a burst-load engine.
// Ports: clk/resetn (sync, active-low), wr_* direct write with bit mask,
// rd_addr/rd_data registered read, ld_* handshaked burst load,
// rf_flat parallel view of every register.
module comefa_rf_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [DATA_WIDTH-1:0]          wr_mask,
  input  logic [ADDR_WIDTH-1:0]          rd_addr,
  output logic [DATA_WIDTH-1:0]          rd_data,
  input  logic                           ld_start,
  input  logic [ADDR_WIDTH-1:0]          ld_base,
  input  logic [ADDR_WIDTH:0]            ld_count,
  input  logic                           ld_valid,
  input  logic [DATA_WIDTH-1:0]          ld_data,
  output logic                           ld_ready,
  output logic                           ld_busy,
  output logic                           ld_done,
  output logic [NUM_REGS*DATA_WIDTH-1:0] rf_flat
);

  typedef enum logic {IDLE, LOAD} state_t;

  localparam logic [ADDR_WIDTH:0] NREGS =
    (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(NUM_REGS-1);
  localparam logic [ADDR_WIDTH:0] ONE =
    (ADDR_WIDTH+1)'(1);

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] regs     [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_nxt [NUM_REGS];

  logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;
  logic [ADDR_WIDTH:0]   rem, rem_nxt;
  logic                  done_q, done_nxt;
  logic                  beat, wr_ok, rd_ok, start_ok;

  // Addresses are wider than the register count when NUM_REGS is
  // not a power of two, so every port is range-checked.
  assign wr_ok    = wr_en && ({1'b0, wr_addr} < NREGS);
  assign rd_ok    = {1'b0, rd_addr} < NREGS;
  assign start_ok = ld_start && (ld_count != '0)
                 && ({1'b0, ld_base} < NREGS);
  assign beat     = ld_valid && ld_ready;
  assign ld_done  = done_q;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    rem_nxt   = rem;
    done_nxt  = 1'b0;
    ld_ready  = 1'b0;
    ld_busy   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_ok) begin
          state_nxt = LOAD;
          ptr_nxt   = ld_base;
          rem_nxt   = ld_count;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        ld_busy  = 1'b1;
        if (ld_valid) begin
          ptr_nxt = (ptr == LAST) ? '0 : ptr + 1'b1;
          rem_nxt = rem - ONE;
          if (rem == ONE) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Load beat first, then the masked direct write on top of it, so a
  // collision keeps direct bits where the mask is set.
  always_comb begin
    regs_nxt = regs;
    if (beat)
      regs_nxt[ptr] = ld_data;
    if (wr_ok)
      regs_nxt[wr_addr] = (regs_nxt[wr_addr] & ~wr_mask)
                        | (wr_data & wr_mask);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      ptr     <= '0;
      rem     <= '0;
      done_q  <= 1'b0;
      rd_data <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      rem     <= rem_nxt;
      done_q  <= done_nxt;
      regs    <= regs_nxt;
      rd_data <= rd_ok ? regs_nxt[rd_addr] : '0;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign rf_flat[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule
